id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register of the pipelined CPU, downstream of the register file read ports. It captures the decoded instruction and both operands each cycle. It bypasses the same-cycle register-file write into the captured operands and detects load-use hazards, inserting one bubble per hazard. It also honours a downstream stall and a branch flush, and keeps a saturating bubble counter.

## Interface
Parameters:
- WIDTH, 32, datapath width
- ADDR_WIDTH, 5, register address width
- CTRL_WIDTH, 12, opaque control bundle width

Ports:
- clock  in  1  clock; all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- id_valid  in  1  decode slot holds a real instruction
- id_rs, id_rt, id_rd  in  ADDR_WIDTH  decoded register addresses
- id_uses_rs, id_uses_rt  in  1  instruction actually reads rs / rt
- id_rdata1, id_rdata2  in  WIDTH  register file read data for rs / rt
- id_imm  in  WIDTH  sign/zero-extended immediate
- id_ctrl  in  CTRL_WIDTH  control bundle
- id_mem_read  in  1  instruction is a load
- wb_en, wb_addr, wb_data  in  1 / ADDR_WIDTH / WIDTH  copy of register file write port
- ext_stall  in  1  downstream cannot accept; hold stage
- flush  in  1  decode slot is wrong-path; kill it
- hazard_stall  out  1  freeze PC and IF/ID this cycle
- ex_valid, ex_mem_read  out  1  registered
- ex_rs, ex_rt, ex_rd  out  ADDR_WIDTH  registered
- ex_a, ex_b, ex_imm  out  WIDTH  registered operands / immediate
- ex_ctrl  out  CTRL_WIDTH  registered
- bubble_cnt  out  16  load-use bubbles inserted, saturating

## Operation
- Reset value: all outputs zero, including bubble_cnt. hazard_stall is 0 while ex_valid=0.
- hazard = ex_valid & ex_mem_read & (ex_rt!=0) & id_valid & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- hazard_stall = hazard & ~flush & ~ext_stall. It is combinational.
- Per-edge priority, highest first:
  - ext_stall: hold all ex_* registers (subject to the bypass rule below).
  - flush: insert a bubble.
  - hazard: insert a bubble and increment bubble_cnt, saturating at 16'hFFFF.
  - Otherwise: capture all id_* fields, with ex_valid <= id_valid.
- Bubble: ex_valid, ex_mem_read and ex_ctrl are set to 0. The address, operand and immediate registers are don't-care; the implementation clears them to 0.
- Operand select for capture, ex_a (ex_b identical with rt / rdata2):
  - id_rs==0 → 0.
  - Bypass hit (see Configuration) → wb_data.
  - Otherwise → id_rdata1.
- flush asserted during ext_stall is ignored. The source holds flush until a non-stalled edge.
- Reset asserted mid-operation clears everything immediately. No partial capture survives.

## Timing
- Capture latency is 1 cycle: ID values sampled at edge N appear on ex_* after edge N.
- Load-use costs exactly 1 bubble:
  - Cycle N: hazard_stall=1.
  - Edge N: bubble enters EX and IF/ID is held.
  - Cycle N+1: ex_mem_read=0, so hazard=0.
  - Edge N+1: the dependent instruction is captured.
- hazard_stall must not depend on wb_* or on any ex_* output through a combinational path from the inputs it drives. There is no loop.
- Bypass compares against wb_* in the same cycle as capture. This covers the register-file write-then-read-same-cycle case, where the register file returns old data.

## Configuration
- Macro: ID_EX_WB_BYPASS_EN.
- Defined:
  - On capture, the operand for rs (rt) takes wb_data when wb_en & wb_addr!=0 & wb_addr==id_rs (id_rt).
  - While held by ext_stall, ex_a (ex_b) is overwritten with wb_data when wb_en & wb_addr!=0 & wb_addr==ex_rs (ex_rt) and ex_valid=1.
- Undefined: operands come only from id_rdata1/2 (r0 still forced 0). Held operands never change. Software or the hazard unit must cover write/read overlap.

## Test plan
- Reset while ex_valid=1 and bubble_cnt=5 → all ex_* and bubble_cnt read 0 before the next clock edge.
- Capture with id_rs=3, id_rdata1=0x11, wb_en=1, wb_addr=3, wb_data=0xAB → ex_a=0xAB next cycle with the macro defined, 0x11 without it. With wb_addr=0 instead of 3 → ex_a=0x11 in both builds.
- EX holds a load with ex_rt=7 and ID reads rt=7 with id_uses_rt=1 → hazard_stall=1 for one cycle. Next cycle ex_valid=0 and bubble_cnt=1; the instruction is captured one edge later.
- Same load with id_rt=7 but id_uses_rt=0, or with ex_rt=0 → hazard_stall=0 and no bubble.
- ext_stall=1 and flush=1 for 3 cycles, then flush held 1 more cycle with ext_stall=0 → ex_* unchanged for 3 cycles, then ex_valid=0 and ex_ctrl=0.
- Force 65536 consecutive load-use hazards → bubble_cnt stops at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register. Each cycle it captures the decoded instruction,
// both register operands and the immediate into the EX stage. It also detects
// load-use hazards, inserting one bubble per hazard, and counts the inserted
// bubbles in a saturating counter. The stage honours a downstream hold
// (ext_stall) and a wrong-path kill (flush).
//
// Optional feature (macro ID_EX_WB_BYPASS_EN):
//   When defined, a register-file write happening in the same cycle as the
//   capture is forwarded into the captured operand. Operands held by
//   ext_stall are refreshed from the write port when their source register
//   is written. When undefined, operands come only from id_rdata1/2, and
//   held operands never change.
//
// Ports:
//   clock, reset                  clock; asynchronous active-high reset
//   id_valid                      decode slot holds a real instruction
//   id_rs/id_rt/id_rd             decoded register addresses
//   id_uses_rs/id_uses_rt         instruction really reads rs / rt
//   id_rdata1/id_rdata2           register file read data for rs / rt
//   id_imm, id_ctrl, id_mem_read  immediate, control bundle, load flag
//   wb_en/wb_addr/wb_data         copy of the register file write port
//   ext_stall                     downstream hold
//   flush                         kill the decode slot
//   hazard_stall                  combinational: freeze PC and IF/ID
//   ex_*                          registered EX-stage fields
//   bubble_cnt                    saturating count of load-use bubbles
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [ADDR_WIDTH-1:0] id_rs,
    input  logic [ADDR_WIDTH-1:0] id_rt,
    input  logic [ADDR_WIDTH-1:0] id_rd,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [WIDTH-1:0]      id_rdata1,
    input  logic [WIDTH-1:0]      id_rdata2,
    input  logic [WIDTH-1:0]      id_imm,
    input  logic [CTRL_WIDTH-1:0] id_ctrl,
    input  logic                  id_mem_read,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [WIDTH-1:0]      wb_data,
    input  logic                  ext_stall,
    input  logic                  flush,
    output logic                  hazard_stall,
    output logic                  ex_valid,
    output logic                  ex_mem_read,
    output logic [ADDR_WIDTH-1:0] ex_rs,
    output logic [ADDR_WIDTH-1:0] ex_rt,
    output logic [ADDR_WIDTH-1:0] ex_rd,
    output logic [WIDTH-1:0]      ex_a,
    output logic [WIDTH-1:0]      ex_b,
    output logic [WIDTH-1:0]      ex_imm,
    output logic [CTRL_WIDTH-1:0] ex_ctrl,
    output logic [15:0]           bubble_cnt
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]      DATA_ZERO = {WIDTH{1'b0}};
    localparam logic [CTRL_WIDTH-1:0] CTRL_ZERO = {CTRL_WIDTH{1'b0}};
    localparam logic [15:0]           CNT_MAX   = 16'hFFFF;

    // EX-stage state
    logic                  ex_valid_r;
    logic                  ex_mem_read_r;
    logic [ADDR_WIDTH-1:0] ex_rs_r;
    logic [ADDR_WIDTH-1:0] ex_rt_r;
    logic [ADDR_WIDTH-1:0] ex_rd_r;
    logic [WIDTH-1:0]      ex_a_r;
    logic [WIDTH-1:0]      ex_b_r;
    logic [WIDTH-1:0]      ex_imm_r;
    logic [CTRL_WIDTH-1:0] ex_ctrl_r;
    logic [15:0]           bubble_cnt_r;

    // Combinational helpers
    logic             hazard_s;
    logic             insert_bubble_s;
    logic [WIDTH-1:0] cap_a_s;
    logic [WIDTH-1:0] cap_b_s;
    logic [WIDTH-1:0] hold_a_s;
    logic [WIDTH-1:0] hold_b_s;

    // Register r0 always reads as zero; every other register passes its data.
    function automatic logic [WIDTH-1:0] zero_r0(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [WIDTH-1:0]      data
    );
        if (addr == ADDR_ZERO) begin
            return DATA_ZERO;
        end else begin
            return data;
        end
    endfunction

    // Load-use hazard. It depends only on registered EX state and the ID
    // inputs, never on wb_*, so there is no combinational loop.
    always_comb begin
        hazard_s = ex_valid_r & ex_mem_read_r & (ex_rt_r != ADDR_ZERO) & id_valid &
                   ((id_uses_rs & (id_rs == ex_rt_r)) |
                    (id_uses_rt & (id_rt == ex_rt_r)));
    end

    assign insert_bubble_s = hazard_s & ~flush & ~ext_stall;
    assign hazard_stall    = insert_bubble_s;

`ifdef ID_EX_WB_BYPASS_EN
    // Operand select for capture and hold, with same-cycle write forwarding.
    always_comb begin
        cap_a_s  = zero_r0(id_rs, id_rdata1);
        cap_b_s  = zero_r0(id_rt, id_rdata2);
        hold_a_s = ex_a_r;
        hold_b_s = ex_b_r;
        if (wb_en && (wb_addr != ADDR_ZERO)) begin
            if (wb_addr == id_rs) begin
                cap_a_s = wb_data;
            end else begin
                cap_a_s = zero_r0(id_rs, id_rdata1);
            end
            if (wb_addr == id_rt) begin
                cap_b_s = wb_data;
            end else begin
                cap_b_s = zero_r0(id_rt, id_rdata2);
            end
            if (ex_valid_r && (wb_addr == ex_rs_r)) begin
                hold_a_s = wb_data;
            end else begin
                hold_a_s = ex_a_r;
            end
            if (ex_valid_r && (wb_addr == ex_rt_r)) begin
                hold_b_s = wb_data;
            end else begin
                hold_b_s = ex_b_r;
            end
        end else begin
            hold_a_s = ex_a_r;
            hold_b_s = ex_b_r;
        end
    end
`else
    // Operand select without forwarding; the write port is not observed.
    logic wb_unused_s;
    assign wb_unused_s = ^{wb_en, wb_addr, wb_data};

    always_comb begin
        cap_a_s  = zero_r0(id_rs, id_rdata1);
        cap_b_s  = zero_r0(id_rt, id_rdata2);
        hold_a_s = ex_a_r;
        hold_b_s = ex_b_r;
    end
`endif

    // EX-stage register: hold, flush bubble, hazard bubble, or capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_valid_r    <= 1'b0;
            ex_mem_read_r <= 1'b0;
            ex_rs_r       <= ADDR_ZERO;
            ex_rt_r       <= ADDR_ZERO;
            ex_rd_r       <= ADDR_ZERO;
            ex_a_r        <= DATA_ZERO;
            ex_b_r        <= DATA_ZERO;
            ex_imm_r      <= DATA_ZERO;
            ex_ctrl_r     <= CTRL_ZERO;
        end else if (ext_stall) begin
            // Hold; only forwarded operands may change.
            ex_a_r <= hold_a_s;
            ex_b_r <= hold_b_s;
        end else if (flush || hazard_s) begin
            ex_valid_r    <= 1'b0;
            ex_mem_read_r <= 1'b0;
            ex_rs_r       <= ADDR_ZERO;
            ex_rt_r       <= ADDR_ZERO;
            ex_rd_r       <= ADDR_ZERO;
            ex_a_r        <= DATA_ZERO;
            ex_b_r        <= DATA_ZERO;
            ex_imm_r      <= DATA_ZERO;
            ex_ctrl_r     <= CTRL_ZERO;
        end else begin
            ex_valid_r    <= id_valid;
            ex_mem_read_r <= id_mem_read;
            ex_rs_r       <= id_rs;
            ex_rt_r       <= id_rt;
            ex_rd_r       <= id_rd;
            ex_a_r        <= cap_a_s;
            ex_b_r        <= cap_b_s;
            ex_imm_r      <= id_imm;
            ex_ctrl_r     <= id_ctrl;
        end
    end

    // Saturating count of load-use bubbles actually inserted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bubble_cnt_r <= 16'h0000;
        end else if (insert_bubble_s && (bubble_cnt_r != CNT_MAX)) begin
            bubble_cnt_r <= bubble_cnt_r + 16'h0001;
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    assign ex_valid    = ex_valid_r;
    assign ex_mem_read = ex_mem_read_r;
    assign ex_rs       = ex_rs_r;
    assign ex_rt       = ex_rt_r;
    assign ex_rd       = ex_rd_r;
    assign ex_a        = ex_a_r;
    assign ex_b        = ex_b_r;
    assign ex_imm      = ex_imm_r;
    assign ex_ctrl     = ex_ctrl_r;
    assign bubble_cnt  = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Scoreboard bench for id_ex_stage. Each stimulus cycle pushes the expected
// hazard_stall for that cycle and the expected EX state after the next edge;
// the monitor pops and compares on falling edges. Expected values are written
// by hand per vector; bypass-dependent values follow ID_EX_WB_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

`ifdef ID_EX_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_uses_rs, id_uses_rt;
    logic [31:0] id_rdata1, id_rdata2, id_imm;
    logic [11:0] id_ctrl;
    logic        id_mem_read;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ext_stall, flush;
    logic        hazard_stall, ex_valid, ex_mem_read;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_a, ex_b, ex_imm;
    logic [11:0] ex_ctrl;
    logic [15:0] bubble_cnt;

    always #5 clock = ~clock;

    id_ex_stage dut (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .id_mem_read(id_mem_read),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ext_stall(ext_stall), .flush(flush), .hazard_stall(hazard_stall),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt)
    );

    typedef struct {
        logic        hz;
        logic        valid;
        logic        mr;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b, imm;
        logic [11:0] ctrl;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " hazard_stall"}, {31'd0, hazard_stall}, 32'd0);
        chk({tag, " ex_valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, " ex_mem_read"}, {31'd0, ex_mem_read}, 32'd0);
        chk({tag, " ex_regs"}, {17'd0, ex_rs, ex_rt, ex_rd}, 32'd0);
        chk({tag, " ex_a"}, ex_a, 32'd0);
        chk({tag, " ex_b"}, ex_b, 32'd0);
        chk({tag, " ex_imm"}, ex_imm, 32'd0);
        chk({tag, " ex_ctrl"}, {20'd0, ex_ctrl}, 32'd0);
        chk({tag, " bubble_cnt"}, {16'd0, bubble_cnt}, 32'd0);
    endtask

    // Monitor: EX state against the previous record, then hazard_stall of the new one.
    initial begin : monitor
        exp_t prev;
        bit   have_prev;
        have_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (have_prev) begin
                chk("ex_valid", {31'd0, ex_valid}, {31'd0, prev.valid});
                chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, prev.mr});
                chk("ex_rs", {27'd0, ex_rs}, {27'd0, prev.rs});
                chk("ex_rt", {27'd0, ex_rt}, {27'd0, prev.rt});
                chk("ex_rd", {27'd0, ex_rd}, {27'd0, prev.rd});
                chk("ex_a", ex_a, prev.a);
                chk("ex_b", ex_b, prev.b);
                chk("ex_imm", ex_imm, prev.imm);
                chk("ex_ctrl", {20'd0, ex_ctrl}, {20'd0, prev.ctrl});
                chk("bubble_cnt", {16'd0, bubble_cnt}, {16'd0, prev.cnt});
            end
            if (exp_q.size() > 0) begin
                prev = exp_q.pop_front();
                chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, prev.hz});
                have_prev = 1'b1;
            end else begin
                have_prev = 1'b0;
            end
        end
    end

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic urs, input logic urt,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [11:0] ctrl, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rs = urs; id_uses_rt = urt;
        id_rdata1 = d1; id_rdata2 = d2; id_imm = imm; id_ctrl = ctrl; id_mem_read = mr;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
        wb_en = en; wb_addr = addr; wb_data = data;
    endtask

    // Called at posedge+2 with inputs applied; returns at the next posedge+2.
    task automatic tick(input logic hz, input logic v, input logic mr,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic [11:0] ctrl, input logic [15:0] cnt);
        exp_t e;
        e.hz = hz; e.valid = v; e.mr = mr; e.rs = rs; e.rt = rt; e.rd = rd;
        e.a = a; e.b = b; e.imm = imm; e.ctrl = ctrl; e.cnt = cnt;
        exp_q.push_back(e);
        @(posedge clock);
        #2;
    endtask

    task automatic bubble(input logic hz, input logic [15:0] cnt);
        tick(hz, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 12'h000, cnt);
    endtask

    // Let the monitor finish every queued record, bounded in cycles.
    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clock);
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d records left, required 0", exp_q.size());
        end
        @(negedge clock);
        #1;
    endtask

    logic [31:0] a8, a9, b10, a16, b17;
    logic [15:0] cnt_m;

    initial begin
        a8  = BYP ? 32'h0000_00AB : 32'h0000_0011;
        a9  = 32'h0000_0011;
        b10 = BYP ? 32'h0000_00CD : 32'h0000_0022;
        a16 = BYP ? 32'h0000_00EE : 32'h0000_0050;
        b17 = BYP ? 32'h0000_00FF : 32'h0000_0060;

        reset = 1'b1;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 12'h000, 1'b0);
        set_wb(1'b0, 5'd0, 32'd0);
        ext_stall = 1'b0;
        flush     = 1'b0;
        #3;
        chk_all_zero("reset_init");
        @(posedge clock);
        #2;
        reset = 1'b0;

        // Load into EX, then a dependent reader of rt: one bubble, then capture.
        set_id(1'b1, 5'd1, 5'd7, 5'd0, 1'b1, 1'b0, 32'h100, 32'h55, 32'd4, 12'h0A5, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 5'd1, 5'd7, 5'd0, 32'h100, 32'h55, 32'd4, 12'h0A5, 16'd0);
        set_id(1'b1, 5'd7, 5'd7, 5'd9, 1'b0, 1'b1, 32'h22, 32'h33, 32'd8, 12'h111, 1'b0);
        bubble(1'b1, 16'd1);
        tick(1'b0, 1'b1, 1'b0, 5'd7, 5'd7, 5'd9, 32'h22, 32'h33, 32'd8, 12'h111, 16'd1);

        // Load again; follower names rt=7 but does not read it: no bubble.
        set_id(1'b1, 5'd1, 5'd7, 5'd0, 1'b1, 1'b0, 32'h100, 32'h55, 32'd4, 12'h0A5, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 5'd1, 5'd7, 5'd0, 32'h100, 32'h55, 32'd4, 12'h0A5, 16'd1);
        set_id(1'b1, 5'd2, 5'd7, 5'd3, 1'b1, 1'b0, 32'h44, 32'h66, 32'd0, 12'h222, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 5'd2, 5'd7, 5'd3, 32'h44, 32'h66, 32'd0, 12'h222, 16'd1);

        // Load to r0 (operand b forced to 0); follower reading r0: no bubble.
        set_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 32'h10, 32'h99, 32'd0, 12'h333, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 5'd1, 5'd0, 5'd0, 32'h10, 32'h0, 32'd0, 12'h333, 16'd1);
        set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 32'h77, 32'h88, 32'd0, 12'h444, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'd0, 12'h444, 16'd1);

        // Same-cycle write to rs=3, then to r0, then to rt=4.
        set_id(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b1, 32'h11, 32'h22, 32'h1000, 12'h555, 1'b0);
        set_wb(1'b1, 5'd3, 32'hAB);
        tick(1'b0, 1'b1, 1'b0, 5'd3, 5'd4, 5'd6, a8, 32'h22, 32'h1000, 12'h555, 16'd1);
        set_wb(1'b1, 5'd0, 32'hAB);
        tick(1'b0, 1'b1, 1'b0, 5'd3, 5'd4, 5'd6, a9, 32'h22, 32'h1000, 12'h555, 16'd1);
        set_wb(1'b1, 5'd4, 32'hCD);
        tick(1'b0, 1'b1, 1'b0, 5'd3, 5'd4, 5'd6, 32'h11, b10, 32'h1000, 12'h555, 16'd1);

        // ext_stall with flush for 3 cycles holds; flush alone then bubbles.
        set_wb(1'b0, 5'd0, 32'd0);
        set_id(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 32'h123, 32'h456, 32'd7, 12'h777, 1'b0);
        ext_stall = 1'b1;
        flush     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b0, 5'd3, 5'd4, 5'd6, 32'h11, b10, 32'h1000, 12'h555, 16'd1);
        end
        ext_stall = 1'b0;
        bubble(1'b0, 16'd1);
        flush = 1'b0;

        // Capture, then writes to the held rs and rt while stalled.
        set_id(1'b1, 5'd5, 5'd6, 5'd1, 1'b1, 1'b1, 32'h50, 32'h60, 32'd2, 12'h666, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 5'd5, 5'd6, 5'd1, 32'h50, 32'h60, 32'd2, 12'h666, 16'd1);
        ext_stall = 1'b1;
        set_wb(1'b1, 5'd5, 32'hEE);
        tick(1'b0, 1'b1, 1'b0, 5'd5, 5'd6, 5'd1, a16, 32'h60, 32'd2, 12'h666, 16'd1);
        set_wb(1'b1, 5'd6, 32'hFF);
        tick(1'b0, 1'b1, 1'b0, 5'd5, 5'd6, 5'd1, a16, b17, 32'd2, 12'h666, 16'd1);

        // Load, then a hazard masked by ext_stall, then by flush.
        ext_stall = 1'b0;
        set_wb(1'b0, 5'd0, 32'd0);
        set_id(1'b1, 5'd2, 5'd7, 5'd0, 1'b1, 1'b1, 32'h1, 32'h2, 32'd0, 12'h0A5, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 5'd2, 5'd7, 5'd0, 32'h1, 32'h2, 32'd0, 12'h0A5, 16'd1);
        ext_stall = 1'b1;
        tick(1'b0, 1'b1, 1'b1, 5'd2, 5'd7, 5'd0, 32'h1, 32'h2, 32'd0, 12'h0A5, 16'd1);
        ext_stall = 1'b0;
        flush     = 1'b1;
        bubble(1'b0, 16'd1);
        flush = 1'b0;

        // 65536 load-use hazards: a self-dependent load alternates capture and bubble.
        cnt_m = 16'd1;
        for (int i = 0; i < 65536; i++) begin
            tick(1'b0, 1'b1, 1'b1, 5'd2, 5'd7, 5'd0, 32'h1, 32'h2, 32'd0, 12'h0A5, cnt_m);
            if (cnt_m != 16'hFFFF) begin
                cnt_m = cnt_m + 16'd1;
            end
            bubble(1'b1, cnt_m);
        end
        tick(1'b0, 1'b1, 1'b1, 5'd2, 5'd7, 5'd0, 32'h1, 32'h2, 32'd0, 12'h0A5, 16'hFFFF);

        // Reset between edges with a valid load in EX and a non-zero counter.
        drain();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 12'h000, 1'b0);
        reset = 1'b1;
        #1;
        chk_all_zero("reset_mid");
        @(posedge clock);
        #2;
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
